// File: rtl/usr_pkg.sv
// Shared mode encodings and serializer FSM states for the universal shift register.
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASHR = 3'b110;
  localparam logic [MODE_W-1:0] MODE_SER  = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFTING
  } usr_state_e;

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit: 8:1 next-state mux selected by the effective mode, plus an
// asynchronously reset flip-flop. Neighbour bits are routed in by the top level.
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic ResetVal = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [MODE_W-1:0] op_i,
  input  logic              d_i,
  input  logic              shl_i,
  input  logic              shr_i,
  input  logic              rotl_i,
  input  logic              rotr_i,
  input  logic              ashr_i,
  output logic              q_o
);

  logic q_d, q_q;

  // Select the next value of this bit from the operation in force.
  always_comb begin
    q_d = q_q;
    unique case (op_i)
      MODE_HOLD: q_d = q_q;
      MODE_SHL:  q_d = shl_i;
      MODE_SHR:  q_d = shr_i;
      MODE_LOAD: q_d = d_i;
      MODE_ROTL: q_d = rotl_i;
      MODE_ROTR: q_d = rotr_i;
      MODE_ASHR: q_d = ashr_i;
      MODE_SER:  q_d = d_i;
      default:   q_d = q_q;
    endcase
  end

  // Bit storage with asynchronous reset to the per-bit reset value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= ResetVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register with an autonomous LSB-first serializer.
// The top owns the serializer FSM, bit counter and Done flag; the datapath is
// WIDTH usr_bit_cell instances fed with pre-wired neighbour vectors.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic [MODE_W-1:0] Mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              Ser_In_L,
  input  logic              Ser_In_R,
  output logic [WIDTH-1:0]  Q,
  output logic              Ser_Out,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  usr_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            done_d, done_q;

  logic [MODE_W-1:0] op;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  shl_v, shr_v, rotl_v, rotr_v, ashr_v;

  // While serializing the external mode is ignored and every edge is an SHR.
  always_comb begin
    op = Mode;
    if (state_q == ST_SHIFTING) begin
      op = MODE_SHR;
    end
  end

  // Candidate next values for every bit, one vector per data-moving mode.
  assign shl_v  = {q[WIDTH-2:0], Ser_In_R};
  assign shr_v  = {Ser_In_L, q[WIDTH-1:1]};
  assign rotl_v = {q[WIDTH-2:0], q[WIDTH-1]};
  assign rotr_v = {q[0], q[WIDTH-1:1]};
  assign ashr_v = {q[WIDTH-1], q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell #(
      .ResetVal(RESET_VAL[i])
    ) u_cell (
      .clk_i (Clk),
      .rst_ni(Resetn),
      .op_i  (op),
      .d_i   (D[i]),
      .shl_i (shl_v[i]),
      .shr_i (shr_v[i]),
      .rotl_i(rotl_v[i]),
      .rotr_i(rotr_v[i]),
      .ashr_i(ashr_v[i]),
      .q_o   (q[i])
    );
  end

  // Serializer sequencing: start on SER, count WIDTH shifts, pulse Done once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Mode == MODE_SER) begin
          state_d = ST_SHIFTING;
          cnt_d   = '0;
        end
      end
      ST_SHIFTING: begin
        if (cnt_q == CntLast) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state; reset aborts any run in progress without a Done pulse.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign Q       = q;
  assign Ser_Out = q[0];
  assign Busy    = (state_q == ST_SHIFTING);
  assign Done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench: the driver updates a behavioural model and queues the expected
// post-edge outputs; a monitor pops one entry after every rising edge and compares.
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = '0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         so;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Resetn = 1'b0;
  logic [2:0]   Mode = MODE_HOLD;
  logic [W-1:0] D = '0;
  logic         Ser_In_L = 1'b0;
  logic         Ser_In_R = 1'b0;
  logic [W-1:0] Q;
  logic         Ser_Out, Busy, Done;

  universal_shift_reg #(
    .WIDTH    (W),
    .RESET_VAL(RV)
  ) dut (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .Mode    (Mode),
    .D       (D),
    .Ser_In_L(Ser_In_L),
    .Ser_In_R(Ser_In_R),
    .Q       (Q),
    .Ser_Out (Ser_Out),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: register value, shifts remaining, done flag.
  logic [W-1:0] m_q;
  int           m_left;
  logic         m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; model computes what the register must hold after the edge.
  task automatic step(input logic [2:0] mode, input logic [W-1:0] d,
                      input logic sl, input logic sr);
    exp_t e;
    @(negedge Clk);
    Mode = mode;
    D = d;
    Ser_In_L = sl;
    Ser_In_R = sr;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_q = (m_q >> 1) | (W'(sl) << (W - 1));
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else begin
      case (mode)
        MODE_SHL:  m_q = (m_q << 1) | W'(sr);
        MODE_SHR:  m_q = (m_q >> 1) | (W'(sl) << (W - 1));
        MODE_LOAD: m_q = d;
        MODE_ROTL: m_q = (m_q << 1) | (m_q >> (W - 1));
        MODE_ROTR: m_q = (m_q >> 1) | (m_q << (W - 1));
        MODE_ASHR: m_q = W'($signed(m_q) >>> 1);
        MODE_SER: begin
          m_q = d;
          m_left = W;
        end
        default: ;
      endcase
    end
    e.q    = m_q;
    e.busy = (m_left > 0);
    e.done = m_done;
    e.so   = m_q[0];
    exp_q.push_back(e);
  endtask

  // Assert reset between edges and check outputs before any clock edge occurs.
  task automatic pulse_reset();
    @(negedge Clk);
    #2 Resetn = 1'b0;
    #1;
    check("rst_q", 32'(Q), 32'(RV));
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    m_q = RV;
    m_left = 0;
    m_done = 1'b0;
    @(negedge Clk);
    Resetn = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("q", 32'(Q), 32'(e.q));
      check("busy", 32'(Busy), 32'(e.busy));
      check("done", 32'(Done), 32'(e.done));
      check("ser_out", 32'(Ser_Out), 32'(e.so));
    end
  end

  initial begin
    m_q = RV;
    m_left = 0;
    m_done = 1'b0;
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;

    // Async reset from an all-ones register.
    step(MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    pulse_reset();

    // Shifts and hold.
    step(MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    step(MODE_SHL, 8'h00, 1'b0, 1'b1);
    step(MODE_SHR, 8'h00, 1'b1, 1'b0);
    repeat (3) step(MODE_HOLD, 8'h00, 1'b0, 1'b0);

    // Rotates and arithmetic shift.
    step(MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step(MODE_ROTL, 8'h00, 1'b0, 1'b0);
    repeat (2) step(MODE_ROTR, 8'h00, 1'b0, 1'b0);
    step(MODE_LOAD, 8'h80, 1'b0, 1'b0);
    repeat (3) step(MODE_ASHR, 8'h00, 1'b0, 1'b0);

    // Plain serializer run followed by an idle cycle.
    step(MODE_SER, 8'h96, 1'b0, 1'b0);
    repeat (W) step(MODE_HOLD, 8'h00, 1'b0, 1'b0);
    step(MODE_HOLD, 8'h00, 1'b0, 1'b0);

    // Mode forced during busy is ignored; back-to-back start in the Done cycle.
    step(MODE_SER, 8'h96, 1'b0, 1'b0);
    repeat (W) step(MODE_LOAD, 8'h55, 1'b0, 1'b0);
    step(MODE_SER, 8'h0F, 1'b0, 1'b0);
    repeat (W) step(MODE_SER, 8'hFF, 1'b0, 1'b0);
    step(MODE_HOLD, 8'h00, 1'b0, 1'b0);

    // Reset at busy cycle 3 aborts the run; a fresh run afterwards is clean.
    step(MODE_SER, 8'h96, 1'b0, 1'b0);
    repeat (3) step(MODE_HOLD, 8'h00, 1'b0, 1'b0);
    pulse_reset();
    repeat (2) step(MODE_HOLD, 8'h00, 1'b0, 1'b0);
    step(MODE_SER, 8'h3C, 1'b1, 1'b0);
    repeat (W + 1) step(MODE_HOLD, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
      end else begin
        step(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    // Drain the scoreboard with a bounded wait.
    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge Clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
